// File: rtl/serial_addsub.sv
// Multi-cycle LSB-first adder/subtractor, BITS_PER_CYCLE bits per clock, valid/ready on both sides.
// Define SATURATE_EN to clamp sum_o to the signed limit (chosen by A's sign) on overflow.
module serial_addsub #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);

  localparam int BPC = BITS_PER_CYCLE;
  localparam int N   = WIDTH / BPC;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % BPC) != 0 || WIDTH < 2) begin : g_bad_param
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             a_sign_q, a_sign_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [BPC:0]     chunk_full;
  logic [BPC-1:0]   chunk_sum;
  logic             chunk_cout;
  logic             final_ovf;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] final_sum;

  always_comb begin
    chunk_full = {1'b0, a_q[BPC-1:0]} + {1'b0, b_q[BPC-1:0]} + {{BPC{1'b0}}, carry_q};
    chunk_sum  = chunk_full[BPC-1:0];
    chunk_cout = chunk_full[BPC];
    // Carry into the chunk MSB recovered from its inputs and sum bit.
    final_ovf  = a_q[BPC-1] ^ b_q[BPC-1] ^ chunk_sum[BPC-1] ^ chunk_cout;
    res_shift  = (res_q >> BPC) | (WIDTH'(chunk_sum) << (WIDTH - BPC));
`ifdef SATURATE_EN
    if (final_ovf) begin
      final_sum = a_sign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      final_sum = res_shift;
    end
`else
    final_sum = res_shift;
`endif
  end

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path leaves a variable unassigned (no latches).
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    a_sign_d = a_sign_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d      = a_i;
          b_d      = sub_i ? ~b_i : b_i;
          carry_d  = sub_i;
          a_sign_d = a_i[WIDTH-1];
          res_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> BPC;
        b_d     = b_q >> BPC;
        res_d   = res_shift;
        carry_d = chunk_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          sum_d   = final_sum;
          cout_d  = chunk_cout;
          ovf_d   = final_ovf;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments; reset clears datapath too so aborted data never leaks out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      a_sign_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      a_sign_q <= a_sign_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE) && !rst_i;
  assign out_valid_o = (state_q == DONE);
  assign sum_o       = sum_q;
  assign carry_o     = cout_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: 8-bit/1-bpc and 16-bit/4-bpc instances against an arithmetic model.
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a_d = '0;
  logic [15:0] b_d = '0;
  logic        sub_d = 1'b0;
  logic        iv8 = 1'b0, iv16 = 1'b0;
  logic        ordy8 = 1'b0, ordy16 = 1'b0;
  logic        ir8, ir16, ov8, ov16, c8, c16, o8, o16;
  logic [7:0]  sum8;
  logic [15:0] sum16;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv8), .in_ready_o(ir8),
    .a_i(a_d[7:0]), .b_i(b_d[7:0]), .sub_i(sub_d), .out_valid_o(ov8),
    .out_ready_i(ordy8), .sum_o(sum8), .carry_o(c8), .overflow_o(o8)
  );

  serial_addsub #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv16), .in_ready_o(ir16),
    .a_i(a_d), .b_i(b_d), .sub_i(sub_d), .out_valid_o(ov16),
    .out_ready_i(ordy16), .sum_o(sum16), .carry_o(c16), .overflow_o(o16)
  );

  function automatic logic rdy(input bit sel);
    return sel ? ir16 : ir8;
  endfunction
  function automatic logic vld(input bit sel);
    return sel ? ov16 : ov8;
  endfunction
  function automatic logic [15:0] rsum(input bit sel);
    return sel ? sum16 : {8'h00, sum8};
  endfunction
  function automatic logic rcar(input bit sel);
    return sel ? c16 : c8;
  endfunction
  function automatic logic rovf(input bit sel);
    return sel ? o16 : o8;
  endfunction

  // Reference: integer arithmetic on unsigned and signed interpretations of the operands.
  function automatic void model(input int w, input int a, input int b, input bit s,
                                output int sum, output bit c, output bit o);
    int m, sa, sb, r;
    m   = 1 << w;
    sum = s ? (a - b + m) % m : (a + b) % m;
    c   = s ? (a >= b) : ((a + b) >= m);
    sa  = (a >= m / 2) ? a - m : a;
    sb  = (b >= m / 2) ? b - m : b;
    r   = s ? sa - sb : sa + sb;
    o   = (r > m / 2 - 1) || (r < -(m / 2));
`ifdef SATURATE_EN
    if (o) sum = (sa < 0) ? m / 2 : m / 2 - 1;
`endif
  endfunction

  // Starts at a negedge, ends at the negedge where out_valid is first seen (result left pending).
  task automatic run_op(input bit sel, input int a, input int b, input bit s,
                        output logic [15:0] sum, output logic c, output logic o,
                        output int lat, output bit to);
    int n;
    n  = 0;
    to = 1'b0;
    while (!rdy(sel) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!rdy(sel)) to = 1'b1;
    a_d = 16'(a);
    b_d = 16'(b);
    sub_d = s;
    if (sel) iv16 = 1'b1; else iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    iv16 = 1'b0;
    lat = 0;
    while (!vld(sel) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!vld(sel)) to = 1'b1;
    sum = rsum(sel);
    c   = rcar(sel);
    o   = rovf(sel);
  endtask

  task automatic handshake(input bit sel);
    if (sel) ordy16 = 1'b1; else ordy8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy8 = 1'b0;
    ordy16 = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({ir8, ov8, sum8, c8, o8} !== 12'h0 || {ir16, ov16, sum16, c16, o16} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got8=%h got16=%h want 0", {ir8, ov8, sum8, c8, o8},
               {ir16, ov16, sum16, c16, o16});
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ir8 !== 1'b1 || ir16 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: got %b%b want 11", ir8, ir16);
    end
    @(negedge clk);
  endtask

  typedef struct { int a; int b; bit s; int wrap; int sat; bit c; bit o; } vec_t;

  task automatic test_directed();
    vec_t v[4];
    logic [15:0] sum;
    logic c, o;
    int lat, exp;
    bit to;
    v[0] = '{32'h5A, 32'h3C, 1'b0, 32'h96, 32'h7F, 1'b0, 1'b1};
    v[1] = '{32'h10, 32'h20, 1'b1, 32'hF0, 32'hF0, 1'b0, 1'b0};
    v[2] = '{32'h80, 32'h01, 1'b1, 32'h7F, 32'h80, 1'b1, 1'b1};
    v[3] = '{32'hFF, 32'h01, 1'b0, 32'h00, 32'h00, 1'b1, 1'b0};
    foreach (v[i]) begin
`ifdef SATURATE_EN
      exp = v[i].sat;
`else
      exp = v[i].wrap;
`endif
      run_op(1'b0, v[i].a, v[i].b, v[i].s, sum, c, o, lat, to);
      n_cmp++;
      if (to || lat != 8) begin
        n_bad++;
        $display("FAIL dir%0d_latency: got %0d (timeout=%0b) want 8", i, lat, to);
      end
      n_cmp++;
      if (sum !== 16'(exp) || c !== v[i].c || o !== v[i].o) begin
        n_bad++;
        $display("FAIL dir%0d_result: got sum=%h c=%b o=%b want sum=%h c=%b o=%b",
                 i, sum, c, o, exp[15:0], v[i].c, v[i].o);
      end
      n_cmp++;
      if (ir8 !== 1'b0) begin
        n_bad++;
        $display("FAIL dir%0d_ready_in_done: got %b want 0", i, ir8);
      end
      handshake(1'b0);
      n_cmp++;
      if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
        n_bad++;
        $display("FAIL dir%0d_post_handshake: got valid=%b ready=%b want 0 1", i, ov8, ir8);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] sum;
    logic c, o;
    int lat, es;
    bit ec, eo, to, bad;
    model(8, 32'h33, 32'h11, 1'b0, es, ec, eo);
    run_op(1'b0, 32'h33, 32'h11, 1'b0, sum, c, o, lat, to);
    bad = 1'b0;
    iv8 = 1'b1;
    repeat (5) begin
      a_d = 16'($urandom_range(0, 255));
      b_d = 16'($urandom_range(0, 255));
      @(negedge clk);
      if (ov8 !== 1'b1 || sum8 !== es[7:0] || ir8 !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (to || bad) begin
      n_bad++;
      $display("FAIL backpressure_hold: got valid=%b sum=%h ready=%b want 1 %h 0", ov8, sum8, ir8, es[7:0]);
    end
    ordy8 = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1 || sum8 !== es[7:0]) begin
      n_bad++;
      $display("FAIL backpressure_release: got valid=%b ready=%b sum=%h want 0 1 %h", ov8, ir8, sum8, es[7:0]);
    end
    @(negedge clk);
    iv8 = 1'b0;
    ordy8 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] sum;
    logic c, o;
    int lat, es;
    bit ec, eo, to, rose;
    a_d = 16'h00C3;
    b_d = 16'h0021;
    sub_d = 1'b0;
    iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({ir8, ov8, sum8, c8, o8} !== 12'h0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got %h want 0", {ir8, ov8, sum8, c8, o8});
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ir8 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_ready: got %b want 1", ir8);
    end
    rose = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ov8 !== 1'b0) rose = 1'b1;
    end
    n_cmp++;
    if (rose) begin
      n_bad++;
      $display("FAIL reset_mid_no_valid: got valid=1 want 0");
    end
    model(8, 32'h47, 32'h9C, 1'b1, es, ec, eo);
    run_op(1'b0, 32'h47, 32'h9C, 1'b1, sum, c, o, lat, to);
    n_cmp++;
    if (to || lat != 8 || sum !== 16'(es) || c !== ec || o !== eo) begin
      n_bad++;
      $display("FAIL reset_mid_next_op: got sum=%h c=%b o=%b lat=%0d want sum=%h c=%b o=%b lat=8",
               sum, c, o, lat, es[15:0], ec, eo);
    end
    handshake(1'b0);
  endtask

  task automatic test_random(input bit sel, input int w, input int exp_lat, input int count);
    logic [15:0] sum;
    logic c, o;
    int lat, es, a, b;
    bit ec, eo, to, s;
    for (int i = 0; i < count; i++) begin
      a = int'($urandom_range(0, (1 << w) - 1));
      b = int'($urandom_range(0, (1 << w) - 1));
      s = 1'($urandom_range(0, 1));
      model(w, a, b, s, es, ec, eo);
      run_op(sel, a, b, s, sum, c, o, lat, to);
      n_cmp++;
      if (to || lat != exp_lat || sum !== 16'(es) || c !== ec || o !== eo) begin
        n_bad++;
        $display("FAIL rand_w%0d_%0d: a=%h b=%h sub=%b got sum=%h c=%b o=%b lat=%0d want sum=%h c=%b o=%b lat=%0d",
                 w, i, a, b, s, sum, c, o, lat, es[15:0], ec, eo, exp_lat);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      handshake(sel);
    end
  endtask

  task automatic test_wide();
    logic [15:0] sum;
    logic c, o;
    int lat, exp;
    bit to;
`ifdef SATURATE_EN
    exp = 32'h7FFF;
`else
    exp = 32'h8000;
`endif
    run_op(1'b1, 32'h7FFF, 32'h0001, 1'b0, sum, c, o, lat, to);
    n_cmp++;
    if (to || lat != 4 || sum !== 16'(exp) || c !== 1'b0 || o !== 1'b1) begin
      n_bad++;
      $display("FAIL wide_7fff_plus_1: got sum=%h c=%b o=%b lat=%0d want sum=%h c=0 o=1 lat=4",
               sum, c, o, lat, exp[15:0]);
    end
    handshake(1'b1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random(1'b0, 8, 8, 30);
    test_wide();
    test_random(1'b1, 16, 4, 30);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised multi-cycle adder/subtractor that processes operands LSB-first in chunks of BITS_PER_CYCLE bits per clock, carrying between chunks in a single flop. It has valid/ready handshakes on input and output, so it can sit between a producer and a consumer in the datapath. It reports carry/borrow and signed overflow. It trades latency for area where a full-width ripple adder is too large.

Parameters:
WIDTH, 8, operand width in bits (>=2)
BITS_PER_CYCLE, 1, bits resolved per clock. WIDTH % BITS_PER_CYCLE must be 0, otherwise elaboration fails.

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous active-high reset
in_valid_i  input  1  operands valid
in_ready_o  output  1  block can accept operands
a_i  input  WIDTH  operand A
b_i  input  WIDTH  operand B
sub_i  input  1  0 = A+B, 1 = A-B
out_valid_o  output  1  result valid
out_ready_i  input  1  consumer accepts result
sum_o  output  WIDTH  result
carry_o  output  1  add: carry out; sub: 1 = no borrow (A>=B unsigned)
overflow_o  output  1  signed (two's complement) overflow

Behaviour:
- N = WIDTH/BITS_PER_CYCLE. Counter wide enough to hold N-1.
- Reset (rst_i high at an edge):
  - state IDLE
  - out_valid_o=0, sum_o=0, carry_o=0, overflow_o=0
  - internal shift registers and counter cleared
  - in_ready_o=0 while rst_i is high, then follows the state.
- Reset has priority over every other event, including mid-operation. An aborted operation never produces out_valid_o.
- in_ready_o = (state==IDLE) & !rst_i. It is combinational from the state.
- IDLE:
  - Operands are accepted on an edge with in_valid_i & in_ready_o.
  - Capture a_i, b_i (or ~b_i when sub_i=1) and sub_i.
  - Carry flop initialised to sub_i.
  - Counter=0, go to RUN.
- RUN:
  - Each edge adds the low BITS_PER_CYCLE bits of the A and B' shift registers plus carry.
  - The chunk result shifts into the result register from the MSB side; the carry flop is updated; the counter increments.
  - On the final chunk (counter==N-1), record signed overflow = carry into MSB XOR carry out of MSB, then go to DONE.
  - in_valid_i is ignored.
- Latency: out_valid_o is asserted on the Nth edge after the accepting edge.
- DONE:
  - out_valid_o=1. sum_o, carry_o and overflow_o are registered and stay stable until the handshake.
  - On an edge with out_ready_i=1: out_valid_o <= 0, go to IDLE.
  - sum_o, carry_o and overflow_o keep their values until the next result.
  - No new acceptance is possible in the same cycle. Minimum initiation interval is N+2 cycles.
- Arithmetic is modulo 2^WIDTH. The carry/borrow convention follows from A + ~B + 1.

Optional Feature:
SATURATE_EN
- Defined: when overflow_o is set, sum_o is replaced by the signed saturation value, chosen by the sign of A:
  - a_i MSB=1: 1 followed by WIDTH-1 zeros (most negative)
  - a_i MSB=0: 0 followed by WIDTH-1 ones (most positive)
  - carry_o and overflow_o are unchanged.
  - The A sign bit is stored at acceptance. Latency is unchanged.
- Not defined: sum_o always holds the wrapped modulo result.

Test Plan:
- WIDTH=8, BPC=1; add 0x5A+0x3C -> sum_o=0x96, carry_o=0, overflow_o=1, out_valid_o 8 edges after accept. With SATURATE_EN: sum_o=0x7F.
- WIDTH=8, BPC=1; sub 0x10-0x20 -> sum_o=0xF0, carry_o=0 (borrow), overflow_o=0. Sub 0x80-0x01 -> 0x7F, carry_o=1, overflow_o=1 (0x80 with SATURATE_EN).
- WIDTH=8, add 0xFF+0x01 -> sum_o=0x00, carry_o=1, overflow_o=0. Then the next operands are accepted only after the output handshake and one IDLE cycle.
- Backpressure: hold out_ready_i=0 for 5 cycles in DONE with in_valid_i=1 and changing a_i -> out_valid_o stays 1, sum_o stable, in_ready_o=0, no new capture. out_ready_i=1 -> out_valid_o falls on that edge.
- Reset mid-operation after 3 RUN edges -> all outputs 0, out_valid_o never rises. in_ready_o=1 on the first cycle with rst_i low. The next operation completes correctly.
- WIDTH=16, BPC=4; add 0x7FFF+0x0001 -> sum_o=0x8000, overflow_o=1, carry_o=0, latency 4 edges. With SATURATE_EN: sum_o=0x7FFF.
